// File: rtl/mips_ram_bus_bridge.sv
// Avalon-style CPU bus to 32-bit word RAM bridge: read wait states and read-modify-write for partial writes.
// Optional range check enabled by defining BRIDGE_RANGE_CHECK_EN.
module mips_ram_bus_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [3:0]            byteenable,
  input  logic [31:0]           writedata,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [31:0]           ram_writedata,
  input  logic [31:0]           ram_readdata,
  output logic                  err_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    RD_DATA,
    RMW_MERGE
  } state_e;

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] w_offset;
  logic [31:0] w_merged;
  logic        w_in_range;
  logic        w_unused;

  // Modulo-2^32 subtraction: addresses below the window wrap around.
  assign w_offset    = address - BASE_ADDR;
  assign ram_address = w_offset[ADDR_WIDTH+1:2];
  assign w_unused    = ^{w_offset[31:ADDR_WIDTH+2], w_offset[1:0]};

`ifdef BRIDGE_RANGE_CHECK_EN
  logic r_err_sticky;

  assign w_in_range = (w_offset[31:ADDR_WIDTH+2] == '0);
  assign err_sticky = r_err_sticky;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_sticky <= 1'b0;
    end else if (r_state == IDLE && (read || write) && !w_in_range) begin
      r_err_sticky <= 1'b1;
    end
  end
`else
  assign w_in_range = 1'b1;
  assign err_sticky = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_merged = ram_readdata;
    for (int i = 0; i < 4; i++) begin
      if (byteenable[i]) w_merged[8*i +: 8] = writedata[8*i +: 8];
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    w_next_state  = r_state;
    waitrequest   = 1'b1;
    readdata      = 32'h0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = writedata;

    unique case (r_state)
      IDLE: begin
        if (read || write) begin
          if (!w_in_range) begin
            waitrequest = 1'b0;
          end else if (read) begin
            ram_read     = 1'b1;
            w_next_state = RD_DATA;
          end else if (byteenable == 4'hF) begin
            ram_write   = 1'b1;
            waitrequest = 1'b0;
          end else if (byteenable == 4'h0) begin
            waitrequest = 1'b0;
          end else begin
            ram_read     = 1'b1;
            w_next_state = RMW_MERGE;
          end
        end
      end
      RD_DATA: begin
        w_next_state = IDLE;
        if (read) begin
          readdata    = ram_readdata;
          waitrequest = 1'b0;
        end
      end
      RMW_MERGE: begin
        w_next_state = IDLE;
        if (write) begin
          ram_writedata = w_merged;
          ram_write     = 1'b1;
          waitrequest   = 1'b0;
        end
      end
      default: w_next_state = IDLE;
    endcase

    // Reset overrides everything so a half-merged word can never reach the RAM.
    if (!reset_n) begin
      waitrequest = 1'b1;
      readdata    = 32'h0;
      ram_read    = 1'b0;
      ram_write   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_ram_bus_bridge.sv
// Self-checking bench for mips_ram_bus_bridge: directed cases plus random traffic against a word-array model.
module tb_mips_ram_bus_bridge;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          DEPTH = 4096;
  localparam int          BUDGET = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [11:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic        err_sticky;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  mips_ram_bus_bridge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .ram_address  (ram_address),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_writedata(ram_writedata),
    .ram_readdata (ram_readdata),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  // Environment RAM: registered read, whole-word write.
  always @(posedge clk) begin
    if (ram_read) ram_readdata <= mem[ram_address];
    if (ram_write) mem[ram_address] <= ram_writedata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output int lat, output logic [31:0] rdata,
                      output int n_wr, output int n_rd, output logic [11:0] addr0);
    read       = rd;
    write      = wr;
    address    = addr;
    byteenable = be;
    writedata  = wd;
    lat  = 1;
    n_wr = 0;
    n_rd = 0;
    #1;
    addr0 = ram_address;
    forever begin
      n_wr = n_wr + int'(ram_write);
      n_rd = n_rd + int'(ram_read);
      if (!waitrequest) break;
      if (lat >= BUDGET) begin
        check("timeout_waitrequest", 32'(waitrequest), 32'h0);
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    rdata = readdata;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  initial begin
    int          lat, n_wr, n_rd, op, idx;
    logic [31:0] rdata, wd, a;
    logic [11:0] a0;
    logic [3:0]  be;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    ram_readdata = 32'h0;
    reset_n = 1'b0;
    read = 1'b0; write = 1'b0; address = BASE; byteenable = 4'h0; writedata = 32'h0;

    @(negedge clk); #1;
    check("rst_waitrequest", 32'(waitrequest), 32'h1);
    check("rst_ram_read", 32'(ram_read), 32'h0);
    check("rst_ram_write", 32'(ram_write), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_err_sticky", 32'(err_sticky), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full write then readback.
    xfer(1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'hDEADBEEF, lat, rdata, n_wr, n_rd, a0);
    ref_mem[4] = 32'hDEADBEEF;
    check("wr_full_latency", 32'(lat), 32'd1);
    check("wr_full_ram_write", 32'(n_wr), 32'd1);
    check("wr_full_ram_address", 32'(a0), 32'h004);
    xfer(1'b1, 1'b0, 32'hBFC00010, 4'h0, 32'h0, lat, rdata, n_wr, n_rd, a0);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data", rdata, 32'hDEADBEEF);

    // Partial write merges one lane.
    mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    xfer(1'b0, 1'b1, 32'hBFC00010, 4'b0010, 32'h0000AB00, lat, rdata, n_wr, n_rd, a0);
    check("rmw_latency", 32'(lat), 32'd2);
    check("rmw_ram_write", 32'(n_wr), 32'd1);
    check("rmw_mem", mem[4], 32'h1122AB44);
    ref_mem[4] = 32'h1122AB44;
    xfer(1'b1, 1'b0, 32'hBFC00010, 4'h0, 32'h0, lat, rdata, n_wr, n_rd, a0);
    check("rmw_readback", rdata, 32'h1122AB44);

    // Back-to-back reads of words 0..7.
    for (int w = 0; w < 8; w++) begin
      mem[w]     = 32'hC0DE0000 + 32'(w * 32'h0101);
      ref_mem[w] = mem[w];
    end
    for (int w = 0; w < 8; w++) begin
      xfer(1'b1, 1'b0, BASE + 32'(4 * w), 4'h0, 32'h0, lat, rdata, n_wr, n_rd, a0);
      check($sformatf("b2b_latency_%0d", w), 32'(lat), 32'd2);
      check($sformatf("b2b_data_%0d", w), rdata, ref_mem[w]);
    end

    // Reset asserted during the merge cycle.
    read = 1'b0; write = 1'b1; address = BASE + 32'd36; byteenable = 4'b0101; writedata = $urandom;
    #1;
    check("rst_rmw_issue_ram_read", 32'(ram_read), 32'h1);
    @(negedge clk); #1;
    check("rst_rmw_merge_ram_write", 32'(ram_write), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_rmw_gated_ram_write", 32'(ram_write), 32'h0);
    check("rst_rmw_gated_wait", 32'(waitrequest), 32'h1);
    @(negedge clk); #1;
    check("rst_rmw_hold_ram_write", 32'(ram_write), 32'h0);
    check("rst_rmw_hold_ram_read", 32'(ram_read), 32'h0);
    check("rst_rmw_hold_wait", 32'(waitrequest), 32'h1);
    write = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rmw_mem_unchanged", mem[9], ref_mem[9]);
    xfer(1'b1, 1'b0, BASE + 32'd36, 4'h0, 32'h0, lat, rdata, n_wr, n_rd, a0);
    check("rst_rmw_idle_latency", 32'(lat), 32'd2);
    check("rst_rmw_readback", rdata, ref_mem[9]);

    // Zero byteenable and simultaneous read/write.
    xfer(1'b0, 1'b1, BASE + 32'd8, 4'h0, 32'h12345678, lat, rdata, n_wr, n_rd, a0);
    check("be0_latency", 32'(lat), 32'd1);
    check("be0_ram_write", 32'(n_wr), 32'd0);
    check("be0_mem", mem[2], ref_mem[2]);
    xfer(1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h87654321, lat, rdata, n_wr, n_rd, a0);
    check("rdwr_latency", 32'(lat), 32'd2);
    check("rdwr_ram_write", 32'(n_wr), 32'd0);
    check("rdwr_data", rdata, ref_mem[2]);

    // Random traffic over the first 16 words; low address bits must be ignored.
    for (int t = 0; t < 60; t++) begin
      op  = $urandom_range(0, 4);
      idx = $urandom_range(0, 15);
      a   = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      wd  = $urandom;
      unique case (op)
        0: begin
          xfer(1'b1, 1'b0, a, 4'($urandom), wd, lat, rdata, n_wr, n_rd, a0);
          check("rnd_rd_latency", 32'(lat), 32'd2);
          check("rnd_rd_data", rdata, ref_mem[idx]);
        end
        1: begin
          xfer(1'b0, 1'b1, a, 4'hF, wd, lat, rdata, n_wr, n_rd, a0);
          ref_mem[idx] = wd;
          check("rnd_full_latency", 32'(lat), 32'd1);
          check("rnd_full_mem", mem[idx], ref_mem[idx]);
        end
        2: begin
          be = 4'($urandom_range(1, 14));
          xfer(1'b0, 1'b1, a, be, wd, lat, rdata, n_wr, n_rd, a0);
          ref_mem[idx] = merge(ref_mem[idx], wd, be);
          check("rnd_part_latency", 32'(lat), 32'd2);
          check("rnd_part_mem", mem[idx], ref_mem[idx]);
        end
        3: begin
          xfer(1'b0, 1'b1, a, 4'h0, wd, lat, rdata, n_wr, n_rd, a0);
          check("rnd_be0_latency", 32'(lat), 32'd1);
          check("rnd_be0_writes", 32'(n_wr), 32'd0);
        end
        default: begin
          xfer(1'b1, 1'b1, a, 4'($urandom), wd, lat, rdata, n_wr, n_rd, a0);
          check("rnd_rdwr_latency", 32'(lat), 32'd2);
          check("rnd_rdwr_writes", 32'(n_wr), 32'd0);
          check("rnd_rdwr_data", rdata, ref_mem[idx]);
        end
      endcase
      check("rnd_ram_address", 32'(a0), 32'(idx));
    end

    // Address below the window.
    xfer(1'b1, 1'b0, 32'h00000000, 4'h0, 32'h0, lat, rdata, n_wr, n_rd, a0);
`ifdef BRIDGE_RANGE_CHECK_EN
    check("oor_latency", 32'(lat), 32'd1);
    check("oor_ram_read", 32'(n_rd), 32'd0);
    check("oor_readdata", rdata, 32'h0);
    check("oor_err_sticky", 32'(err_sticky), 32'h1);
`else
    check("wrap_ram_address", 32'(a0), 32'h000);
    check("wrap_latency", 32'(lat), 32'd2);
    check("wrap_readdata", rdata, ref_mem[0]);
    check("wrap_err_sticky", 32'(err_sticky), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
